// File: rtl/tlb_idma_mutex_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_idma_mutex_ctrl
// Brief    : Ownership arbiter for the shared TLB iDMA request channel.
//            Grants the read- or write-side miss handler exclusive use of
//            the channel (round-robin on contention), holds the grant until
//            release, then drains outstanding ctl requests before
//            re-arbitrating. Drives the rd/wr iDMA arbiter's mutex select.
// Options  : MUTEX_TIMEOUT_EN - ownership watchdog (TIMEOUT_CYCLES) that
//            force-revokes a grant and pulses timeout_irq.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_idma_mutex_ctrl #(
  parameter int OUT_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic                rd_rel,
  input  logic                wr_rel,
  input  logic                idma_issue,
  input  logic                idma_done,
  output logic                rd_gnt,
  output logic                wr_gnt,
  output logic                mutex,
  output logic                busy,
  output logic [OUT_BITS-1:0] outstanding,
  output logic                err,
  output logic                timeout_irq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_OWN = 2'd1,
    S_WR_OWN = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam logic [OUT_BITS-1:0] c_out_max = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_wr;
  logic                w_last_wr_nxt;
  logic                r_mutex;
  logic                w_mutex_nxt;
  logic                r_rd_gnt;
  logic                r_wr_gnt;
  logic                r_busy;
  logic                r_err;
  logic                r_irq;
  logic                w_irq_nxt;
  logic [OUT_BITS-1:0] r_out;
  logic [OUT_BITS-1:0] w_out_nxt;
  logic                w_err_evt;
  logic                w_tmo;

  // Outstanding ctl counter update: saturates at both ends and flags misuse.
  always_comb begin
    w_out_nxt = r_out;
    w_err_evt = 1'b0;
    if (idma_issue && !idma_done) begin
      if (r_out == c_out_max) w_err_evt = 1'b1;
      else                    w_out_nxt = r_out + 1'b1;
    end else if (!idma_issue && idma_done) begin
      if (r_out == '0) w_err_evt = 1'b1;
      else             w_out_nxt = r_out - 1'b1;
    end
  end

`ifdef MUTEX_TIMEOUT_EN
  localparam int                   c_tmr_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tmr_w-1:0]   c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmr_w-1:0] r_tmr;

  // Owned-cycle counter; held at zero whenever nobody owns the channel.
  always_ff @(posedge aclk) begin
    if (!aresetn || r_state == S_IDLE || r_state == S_DRAIN) r_tmr <= '0;
    else                                                     r_tmr <= r_tmr + 1'b1;
  end

  assign w_tmo = (r_tmr == c_tmr_last);
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES < 2);
`endif

  // Next-state, round-robin and mutex selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_wr_nxt = r_last_wr;
    w_mutex_nxt   = r_mutex;
    w_irq_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the handler that did not own last time wins.
        if (rd_req && (!wr_req || r_last_wr)) begin
          w_state_nxt   = S_RD_OWN;
          w_last_wr_nxt = 1'b0;
          w_mutex_nxt   = 1'b0;
        end else if (wr_req) begin
          w_state_nxt   = S_WR_OWN;
          w_last_wr_nxt = 1'b1;
          w_mutex_nxt   = 1'b1;
        end
      end
      S_RD_OWN: begin
        // A release in the watchdog cycle wins and suppresses the irq.
        if (rd_rel) begin
          w_state_nxt = S_DRAIN;
        end else if (w_tmo) begin
          w_state_nxt = S_DRAIN;
          w_irq_nxt   = 1'b1;
        end
      end
      S_WR_OWN: begin
        if (wr_rel) begin
          w_state_nxt = S_DRAIN;
        end else if (w_tmo) begin
          w_state_nxt = S_DRAIN;
          w_irq_nxt   = 1'b1;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the count settles at zero after this cycle's
        // completions, so a final done lets IDLE follow immediately.
        if (w_out_nxt == '0 && !idma_issue) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b1;
      r_mutex   <= 1'b0;
      r_rd_gnt  <= 1'b0;
      r_wr_gnt  <= 1'b0;
      r_busy    <= 1'b0;
      r_out     <= '0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_mutex   <= w_mutex_nxt;
      r_rd_gnt  <= (w_state_nxt == S_RD_OWN);
      r_wr_gnt  <= (w_state_nxt == S_WR_OWN);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_out     <= w_out_nxt;
      r_err     <= r_err | w_err_evt;
      r_irq     <= w_irq_nxt;
    end
  end

  assign rd_gnt      = r_rd_gnt;
  assign wr_gnt      = r_wr_gnt;
  assign mutex       = r_mutex;
  assign busy        = r_busy;
  assign outstanding = r_out;
  assign err         = r_err;
  assign timeout_irq = r_irq;

endmodule
`default_nettype wire
